// File: rtl/hilo_muldiv_unit_if.sv
// ============================================================================
// Module      : hilo_muldiv_unit_if
// Description : EX-stage bus between the decoder and the HI/LO mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hilo_muldiv_unit_if;
  logic        start;
  logic [2:0]  mul_divop;
  logic        ifmuldiv;
  logic        hilowrite;
  logic        hilo;
  logic        ifmfhi;
  logic        ifmflo;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_rdata;

  modport master (
    output start, mul_divop, ifmuldiv, hilowrite, hilo, ifmfhi, ifmflo,
           rs_val, rt_val,
    input  busy, stall, hi, lo, hilo_rdata
  );

  modport slave (
    input  start, mul_divop, ifmuldiv, hilowrite, hilo, ifmfhi, ifmflo,
           rs_val, rt_val,
    output busy, stall, hi, lo, hilo_rdata
  );
endinterface

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : Fixed-latency mult/div resource owning the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic         clk,
  input  wire logic         reset,
  hilo_muldiv_unit_if.slave bus
);

  localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, lo_q;
  logic [31:0] sh_hi_q, sh_lo_q;
  logic        sh_wr_q;

  logic        w_accept;
  logic        w_commit;
  logic        w_is_div;
  logic        w_signed;
  logic        w_rs_neg, w_rt_neg;
  logic [31:0] w_rs_mag, w_rt_mag;
  logic [31:0] w_q_mag, w_r_mag;
  logic [31:0] w_quot, w_rem;
  logic [63:0] w_prod_s, w_prod_u;
  logic [63:0] w_result;

  assign w_accept = (state_q == S_IDLE) && bus.start && !bus.mul_divop[2];
  assign w_commit = (state_q == S_BUSY) && (cnt_q == 4'd1);
  assign w_is_div = bus.mul_divop[1];
  assign w_signed = bus.mul_divop[0];

  // Products are formed on 64-bit extended operands so truncation is exact.
  assign w_prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                    $signed({{32{bus.rt_val[31]}}, bus.rt_val});
  assign w_prod_u = {32'h0, bus.rs_val} * {32'h0, bus.rt_val};

  // Signed division runs on magnitudes; this also makes MIN/-1 wrap cleanly.
  // A zero divisor is replaced by 1 so the divider never sees x/0.
  always_comb begin
    w_rs_neg = w_signed && bus.rs_val[31];
    w_rt_neg = w_signed && bus.rt_val[31];
    w_rs_mag = w_rs_neg ? (32'h0 - bus.rs_val) : bus.rs_val;
    w_rt_mag = (bus.rt_val == 32'h0) ? 32'h1 :
               (w_rt_neg ? (32'h0 - bus.rt_val) : bus.rt_val);
    w_q_mag  = w_rs_mag / w_rt_mag;
    w_r_mag  = w_rs_mag % w_rt_mag;
    w_quot   = (w_rs_neg ^ w_rt_neg) ? (32'h0 - w_q_mag) : w_q_mag;
    w_rem    = w_rs_neg ? (32'h0 - w_r_mag) : w_r_mag;
  end

  always_comb begin
    w_result = 64'h0;
    if (w_is_div) begin
      w_result = {w_rem, w_quot};
    end else if (w_signed) begin
      w_result = w_prod_s;
    end else begin
      w_result = w_prod_u;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_BUSY;
          cnt_d   = w_is_div ? C_DIV_CNT : C_MULT_CNT;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Divide-by-zero still burns the full latency but suppresses the commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      sh_hi_q <= 32'h0;
      sh_lo_q <= 32'h0;
      sh_wr_q <= 1'b0;
    end else begin
      if (w_accept) begin
        sh_hi_q <= w_result[63:32];
        sh_lo_q <= w_result[31:0];
        sh_wr_q <= !(w_is_div && (bus.rt_val == 32'h0));
      end
      if (w_commit && sh_wr_q) begin
        hi_q <= sh_hi_q;
        lo_q <= sh_lo_q;
      end
      if ((state_q == S_IDLE) && bus.hilowrite) begin
        if (bus.hilo) begin
          hi_q <= bus.rs_val;
        end else begin
          lo_q <= bus.rs_val;
        end
      end
    end
  end

  assign bus.busy       = (state_q == S_BUSY);
  assign bus.stall      = bus.busy &&
                          (bus.ifmuldiv || bus.ifmfhi || bus.ifmflo || bus.hilowrite);
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.hilo_rdata = bus.ifmfhi ? hi_q : (bus.ifmflo ? lo_q : 32'h0);

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// Module      : tb_hilo_muldiv_unit
// Description : Scoreboard bench for hilo_muldiv_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk;
  logic reset;
  hilo_muldiv_unit_if bus_if ();

  hilo_muldiv_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;
  logic aborting  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every falling edge of busy is a commit point to score.
  always @(negedge clk) begin
    if (bus_if.busy) begin
      busy_cnt++;
    end else if (prev_busy) begin
      if (!aborting) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got commit with empty queue expected none");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("commit_hi", bus_if.hi, e.hi);
          check("commit_lo", bus_if.lo, e.lo);
          check("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
        end
      end
      busy_cnt = 0;
    end
    prev_busy = bus_if.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.start     = 1'b0;
    bus_if.mul_divop = 3'b000;
    bus_if.ifmuldiv  = 1'b0;
    bus_if.hilowrite = 1'b0;
    bus_if.hilo      = 1'b0;
    bus_if.ifmfhi    = 1'b0;
    bus_if.ifmflo    = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cycles = cyc;
    sb_q.push_back(e);
    bus_if.start     = 1'b1;
    bus_if.ifmuldiv  = 1'b1;
    bus_if.mul_divop = op;
    bus_if.rs_val    = rs;
    bus_if.rt_val    = rt;
    tick();
    clear_inputs();
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (bus_if.busy && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (bus_if.busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got busy after 50 cycles expected idle", name);
    end
  endtask

  task automatic move_to(input logic to_hi, input logic [31:0] val);
    bus_if.hilowrite = 1'b1;
    bus_if.hilo      = to_hi;
    bus_if.rs_val    = val;
    tick();
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    reset = 1'b0;
    bus_if.rs_val = 32'h0;
    bus_if.rt_val = 32'h0;
    clear_inputs();
    bus_if.ifmfhi   = 1'b1;
    bus_if.ifmuldiv = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus_if.busy), 32'h0);
    check("rst_stall", 32'(bus_if.stall), 32'h0);
    check("rst_hi", bus_if.hi, 32'h0);
    check("rst_lo", bus_if.lo, 32'h0);
    check("rst_rdata", bus_if.hilo_rdata, 32'h0);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);

    issue(3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MULT_CYCLES);
    wait_idle("mult");
    issue(3'b000, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MULT_CYCLES);
    wait_idle("multu");
    issue(3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES);
    wait_idle("div");
    issue(3'b010, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYCLES);
    wait_idle("divu");

    move_to(1'b1, 32'hDEAD_BEEF);
    check("mthi_hi", bus_if.hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", bus_if.lo, 32'd14);
    move_to(1'b1, 32'h11);
    move_to(1'b0, 32'h22);
    check("mtlo_lo", bus_if.lo, 32'h22);

    issue(3'b010, 32'd7, 32'd0, 32'h11, 32'h22, DIV_CYCLES);
    wait_idle("div0");
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_CYCLES);
    wait_idle("div_ovf");

    // mflo arrives in EX two cycles after a mult is accepted.
    issue(3'b001, 32'd3, 32'd7, 32'h0, 32'd21, MULT_CYCLES);
    @(negedge clk);
    check("stall_unrelated", 32'(bus_if.stall), 32'h0);
    tick();
    tick();
    bus_if.ifmflo = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (bus_if.stall && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check("mflo_stall_cycles", 32'(cnt), 32'd3);
    check("mflo_rdata", bus_if.hilo_rdata, 32'd21);
    bus_if.ifmflo = 1'b0;
    bus_if.ifmfhi = 1'b1;
    #1;
    check("mfhi_rdata", bus_if.hilo_rdata, 32'h0);
    clear_inputs();
    tick();

    // mtlo held in EX while a mult is in flight.
    issue(3'b000, 32'd4, 32'd5, 32'h0, 32'd20, MULT_CYCLES);
    bus_if.hilowrite = 1'b1;
    bus_if.hilo      = 1'b0;
    bus_if.rs_val    = 32'hCAFE_F00D;
    @(negedge clk);
    check("mtlo_stalled", 32'(bus_if.stall), 32'h1);
    cnt = 0;
    while (bus_if.stall && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    check("mtlo_after_lo", bus_if.lo, 32'hCAFE_F00D);
    check("mtlo_after_hi", bus_if.hi, 32'h0);

    // Second mult waits in EX and is accepted on the first idle cycle.
    issue(3'b001, 32'd6, 32'd7, 32'h0, 32'd42, MULT_CYCLES);
    begin
      exp_t e;
      e.hi = 32'h0; e.lo = 32'd6; e.cycles = MULT_CYCLES;
      sb_q.push_back(e);
    end
    bus_if.start     = 1'b1;
    bus_if.ifmuldiv  = 1'b1;
    bus_if.mul_divop = 3'b001;
    bus_if.rs_val    = 32'd2;
    bus_if.rt_val    = 32'd3;
    cnt = 0;
    @(negedge clk);
    while (bus_if.stall && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check("b2b_stall_cycles", 32'(cnt), 32'(MULT_CYCLES));
    tick();
    clear_inputs();
    @(negedge clk);
    check("b2b_accepted", 32'(bus_if.busy), 32'h1);
    wait_idle("b2b");

    bus_if.start     = 1'b1;
    bus_if.ifmuldiv  = 1'b1;
    bus_if.mul_divop = 3'b100;
    bus_if.rs_val    = 32'd9;
    bus_if.rt_val    = 32'd9;
    tick();
    clear_inputs();
    @(negedge clk);
    check("illegal_busy", 32'(bus_if.busy), 32'h0);
    check("illegal_lo", bus_if.lo, 32'd6);

    // Reset asserted in the fourth busy cycle of a div.
    aborting = 1'b1;
    bus_if.start     = 1'b1;
    bus_if.ifmuldiv  = 1'b1;
    bus_if.mul_divop = 3'b011;
    bus_if.rs_val    = 32'd50;
    bus_if.rt_val    = 32'd5;
    tick();
    clear_inputs();
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus_if.busy), 32'h0);
    check("abort_hi", bus_if.hi, 32'h0);
    check("abort_lo", bus_if.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_commit_lo", bus_if.lo, 32'h0);
    check("abort_no_commit_busy", 32'(bus_if.busy), 32'h0);
    aborting = 1'b0;

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
